mat_mem_1632_resp: RTL and testbench
====================================

MAT_MEM_1632_RESP -- requirements
Module: mat_mem_1632_resp

Interface
REQ-001 SHALL have parameters ROWS_A=16 (rows of A/C), COLS_A=49 (A columns = B rows), COLS_B=32 (columns of B/C).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have ports host_we, host_sel, host_addr and host_wdata, all inputs, of widths 1, 1, 11 and 16: host load strobe, target select (0=A, 1=B), word address, and signed data.
REQ-005 SHALL have ports host_raddr (input, 9 bits) and host_rdata (output, 32 bits), plus host_rvalid (output, 1 bit): C readback address, signed data, and data-valid flag.
REQ-006 SHALL have port host_go, input, 1 bit: run request pulse.
REQ-007 SHALL have outputs busy, cmpl and err (widths 1, 1 and 4): run in progress, completion pulse, and sticky errors {dup, unexp, range, cnt}.
REQ-008 SHALL have port start, output, 1 bit: one-cycle start pulse to the multiplier.
REQ-009 SHALL have ports addr_a (input, 10 bits) and data_a (output, signed 16 bits): multiplier read port for A.
REQ-010 SHALL have ports addr_b (input, 11 bits) and data_b (output, signed 16 bits): multiplier read port for B.
REQ-011 SHALL have ports addr_c (input, 9 bits), data_c (input, signed 32 bits), we_c (input, 1 bit) and done (input, 1 bit): C write port and multiplier completion.

Function
REQ-012 SHALL hold A as 784x16, B as 1568x16 and C as 512x32 arrays, row-major.
REQ-013 SHALL drive data_a and data_b combinationally from addr_a and addr_b, with zero latency, and return 0 for out-of-range addresses (A ≥784, B ≥1568).
REQ-014 SHALL implement FSM states IDLE, START, RUN and CMPL.
REQ-015 In IDLE, SHALL go to START when host_go=1, otherwise stay in IDLE.
REQ-016 START SHALL always go to RUN.
REQ-017 RUN SHALL go to CMPL when done=1.
REQ-018 CMPL SHALL always go to IDLE.
REQ-019 SHALL assert start exactly during START; busy SHALL be 1 in START and RUN.
REQ-020 SHALL assert cmpl for exactly one cycle, during CMPL.
REQ-021 In IDLE, host_we SHALL write host_wdata to A or B at host_addr; if host_addr ≥784 (A) or ≥1568 (B), the write SHALL be dropped and err[1] set.
REQ-022 Outside IDLE, host_we SHALL be ignored, with no error.
REQ-023 When host_go and host_we are asserted in the same IDLE cycle, the write SHALL complete and the go SHALL be accepted.
REQ-024 host_go SHALL be ignored outside IDLE.
REQ-025 Accepting host_go SHALL clear err and the 10-bit write counter wr_cnt.
REQ-026 In RUN, we_c=1 SHALL write data_c to C[addr_c] and increment wr_cnt, saturating at 1023.
REQ-027 An addr_c ≥512 in RUN SHALL drop the write and set err[1].
REQ-028 we_c asserted in any state other than RUN SHALL be dropped and set err[2].
REQ-029 When we_c and done are asserted in the same cycle, the write SHALL be counted before the done check.
REQ-030 On the RUN→CMPL transition, SHALL set err[0] if the final wr_cnt ≠ 512.
REQ-031 host_rdata SHALL be registered with 1-cycle latency: host_rdata = C[host_raddr] from the prior cycle, host_rvalid=1 that cycle.
REQ-032 host_rdata SHALL be valid only in IDLE; otherwise host_rvalid=0 and host_rdata holds its value.

Reset
REQ-033 reset_n=0 SHALL force the FSM to IDLE, clear wr_cnt and the dup bitmap, and drive start, busy, cmpl, err, host_rvalid and host_rdata to 0.
REQ-034 Array contents SHALL NOT be reset.
REQ-035 Reset asserted mid-RUN SHALL abort the run; no cmpl SHALL be issued.

Configuration
REQ-036 With MAT_MEM_DUP_CHECK_EN defined, SHALL keep a 512-bit written bitmap, cleared on go acceptance.
REQ-037 With MAT_MEM_DUP_CHECK_EN defined, a RUN write to an already-marked address SHALL still be performed and SHALL set err[3].
REQ-038 Without MAT_MEM_DUP_CHECK_EN, the bitmap SHALL be absent and err[3] SHALL be tied to 0.

Structure
REQ-039 Package mat_1632_pkg SHALL hold ROWS_A, COLS_A, COLS_B, the depths 784/1568/512, the FSM state encoding and the err bit indices.
REQ-040 One sub-module mat_1632_sram SHALL be used, parameterized by depth and width, with an async-read port and a sync-write port, instanced three times.

Verification
REQ-041 Load A[i]=1 and B[i]=2 in IDLE, pulse host_go, then run the multiplier -> start pulses once, 512 C writes occur, cmpl pulses once, err=0, and every C word reads back 98.
REQ-042 Write host A at addr 800 -> dropped, err[1]=1; a later accepted host_go -> err=0.
REQ-043 Assert done after 511 writes -> cmpl pulses, err[0]=1.
REQ-044 we_c and done together on the 512th write -> err[0]=0 and the last word is stored.
REQ-045 Write addr_c=5 twice in RUN -> err[3]=1 with MAT_MEM_DUP_CHECK_EN defined, err[3]=0 without, and C[5] holds the second value in both builds.
REQ-046 Pull reset_n low mid-RUN -> busy=0 and no cmpl is issued; a subsequent host_go then completes normally.

Source files
------------

// File: rtl/mat_1632_pkg.sv
// mat_1632_pkg: shared constants for the 16x49 * 49x32 matrix memory block.
//   - Matrix geometry (ROWS_A, COLS_A, COLS_B) and array depths for A, B, C.
//   - FSM state encoding used by mat_mem_1632_resp.
//   - Bit positions inside the sticky err vector {dup, unexp, range, cnt}.
//   - in_range(): bounds test done on a 32-bit widened address so that
//     narrow address buses compare cleanly against the array depth.
package mat_1632_pkg;

  localparam int ROWS_A = 16;
  localparam int COLS_A = 49;
  localparam int COLS_B = 32;

  localparam int unsigned DEPTH_A = 784;   // ROWS_A * COLS_A
  localparam int unsigned DEPTH_B = 1568;  // COLS_A * COLS_B
  localparam int unsigned DEPTH_C = 512;   // ROWS_A * COLS_B

  localparam int AW_A  = 10;
  localparam int AW_B  = 11;
  localparam int AW_C  = 9;
  localparam int DW_AB = 16;
  localparam int DW_C  = 32;
  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_CMPL  = 2'd3
  } state_t;

  localparam int ERR_CNT   = 0;
  localparam int ERR_RANGE = 1;
  localparam int ERR_UNEXP = 2;
  localparam int ERR_DUP   = 3;

  function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mat_1632_sram.sv
// mat_1632_sram: simple storage array, async read / sync write.
//   Parameters: DEPTH (words), WIDTH (bits/word), AW (address bits).
//   Ports:
//     clk          - write clock
//     we/waddr/wdata - write strobe, address, data (caller filters range)
//     raddr/rdata  - combinational read; addresses >= DEPTH read as 0
//   Contents are never reset.
module mat_1632_sram #(
  parameter int unsigned DEPTH = 512,
  parameter int          WIDTH = 32,
  parameter int          AW    = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The address bus can span past DEPTH (e.g. 10 bits for 784 words);
  // those holes read back as zero rather than X.
  always_comb begin
    rdata = '0;
    if (32'(raddr) < DEPTH) rdata = mem[raddr];
  end

endmodule

// File: rtl/mat_mem_1632_resp.sv
// mat_mem_1632_resp: operand/result memory and run sequencer for a
// 16x49 * 49x32 signed matrix multiplier.
//   Host side : host_we/host_sel/host_addr/host_wdata load A (sel=0) or B
//               (sel=1) while idle; host_raddr -> host_rdata/host_rvalid reads
//               C with one cycle latency while idle; host_go starts a run.
//   Status    : busy (START/RUN), cmpl (one-cycle pulse), err sticky
//               {dup, unexp, range, cnt}, cleared when a go is accepted.
//   Multiplier: start pulse, zero-latency reads addr_a->data_a and
//               addr_b->data_b, result writes addr_c/data_c/we_c, done.
//   Optional  : MAT_MEM_DUP_CHECK_EN adds a per-word written bitmap for C and
//               flags rewrites of the same word in err[3].
module mat_mem_1632_resp #(
  parameter int ROWS_A = mat_1632_pkg::ROWS_A,
  parameter int COLS_A = mat_1632_pkg::COLS_A,
  parameter int COLS_B = mat_1632_pkg::COLS_B
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               host_we,
  input  logic               host_sel,
  input  logic [10:0]        host_addr,
  input  logic signed [15:0] host_wdata,
  input  logic [8:0]         host_raddr,
  output logic signed [31:0] host_rdata,
  output logic               host_rvalid,
  input  logic               host_go,
  output logic               busy,
  output logic               cmpl,
  output logic [3:0]         err,
  output logic               start,
  input  logic [9:0]         addr_a,
  output logic signed [15:0] data_a,
  input  logic [10:0]        addr_b,
  output logic signed [15:0] data_b,
  input  logic [8:0]         addr_c,
  input  logic signed [31:0] data_c,
  input  logic               we_c,
  input  logic               done
);
  import mat_1632_pkg::*;

  localparam int unsigned DA = ROWS_A * COLS_A;
  localparam int unsigned DB = COLS_A * COLS_B;
  localparam int unsigned DC = ROWS_A * COLS_B;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      wr_cnt, cnt_nx;
  logic                  idle, run, go_acc;
  logic                  host_in_rng, wa_en, wb_en, host_rng_err;
  logic                  c_in_rng, wc_en, c_rng_err, c_unexp, c_dup;
  logic [3:0]            err_set;
  logic [DW_C-1:0]       c_rdata;

  always_comb begin
    idle        = (state == S_IDLE);
    run         = (state == S_RUN);
    go_acc      = idle && host_go;

    host_in_rng = host_sel ? in_range(32'(host_addr), DB) : in_range(32'(host_addr), DA);
    wa_en        = idle && host_we && !host_sel && host_in_rng;
    wb_en        = idle && host_we &&  host_sel && host_in_rng;
    host_rng_err = idle && host_we && !host_in_rng;

    c_in_rng  = in_range(32'(addr_c), DC);
    wc_en     = run && we_c && c_in_rng;
    c_rng_err = run && we_c && !c_in_rng;
    c_unexp   = we_c && !run;

    // go and C writes never coincide (IDLE vs RUN), so clear and count are
    // exclusive; the count includes a write landing together with done.
    cnt_nx = go_acc ? '0 : wr_cnt;
    if (wc_en && wr_cnt != CNT_MAX) cnt_nx = wr_cnt + 1'b1;

    state_nx = state;
    case (state)
      S_IDLE:  if (host_go) state_nx = S_START;
      S_START: state_nx = S_RUN;
      S_RUN:   if (done) state_nx = S_CMPL;
      S_CMPL:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    err_set            = '0;
    err_set[ERR_CNT]   = run && done && (32'(cnt_nx) != DC);
    err_set[ERR_RANGE] = host_rng_err || c_rng_err;
    err_set[ERR_UNEXP] = c_unexp;
    err_set[ERR_DUP]   = c_dup;
  end

`ifdef MAT_MEM_DUP_CHECK_EN
  logic [DC-1:0] written;

  // Duplicate writes still land in C; they only raise the flag.
  assign c_dup = wc_en && written[addr_c];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    written <= '0;
    else if (go_acc) written <= '0;
    else if (wc_en)  written[addr_c] <= 1'b1;
  end
`else
  assign c_dup = 1'b0;
`endif

  // Outputs are decoded from the next state so they line up exactly with
  // the cycle the FSM spends in START / RUN / CMPL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      wr_cnt      <= '0;
      err         <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      cmpl        <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      state       <= state_nx;
      wr_cnt      <= cnt_nx;
      err         <= (go_acc ? 4'b0 : err) | err_set;
      start       <= (state_nx == S_START);
      busy        <= (state_nx == S_START) || (state_nx == S_RUN);
      cmpl        <= (state_nx == S_CMPL);
      host_rvalid <= idle;
      if (idle) host_rdata <= c_rdata;
    end
  end

  mat_1632_sram #(.DEPTH(DA), .WIDTH(DW_AB), .AW(AW_A)) u_mem_a (
    .clk   (clk),
    .we    (wa_en),
    .waddr (host_addr[AW_A-1:0]),
    .wdata (host_wdata),
    .raddr (addr_a),
    .rdata (data_a)
  );

  mat_1632_sram #(.DEPTH(DB), .WIDTH(DW_AB), .AW(AW_B)) u_mem_b (
    .clk   (clk),
    .we    (wb_en),
    .waddr (host_addr),
    .wdata (host_wdata),
    .raddr (addr_b),
    .rdata (data_b)
  );

  mat_1632_sram #(.DEPTH(DC), .WIDTH(DW_C), .AW(AW_C)) u_mem_c (
    .clk   (clk),
    .we    (wc_en),
    .waddr (addr_c),
    .wdata (data_c),
    .raddr (host_raddr),
    .rdata (c_rdata)
  );

endmodule

// File: tb/tb_mat_mem_1632_resp.sv
// tb_mat_mem_1632_resp: directed bench with a scoreboard. Stimulus pushes the
// expected C readback words and the expected err value at each completion;
// a negedge monitor pops and compares when host_rvalid data or cmpl appears.
module tb_mat_mem_1632_resp;
  import mat_1632_pkg::*;

`ifdef MAT_MEM_DUP_CHECK_EN
  localparam logic [3:0] DUP_ERR = 4'b1000;
`else
  localparam logic [3:0] DUP_ERR = 4'b0000;
`endif

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               host_we = 1'b0, host_sel = 1'b0;
  logic [10:0]        host_addr = '0;
  logic signed [15:0] host_wdata = '0;
  logic [8:0]         host_raddr = '0;
  logic signed [31:0] host_rdata;
  logic               host_rvalid;
  logic               host_go = 1'b0;
  logic               busy, cmpl, start;
  logic [3:0]         err;
  logic [9:0]         addr_a = '0;
  logic signed [15:0] data_a;
  logic [10:0]        addr_b = '0;
  logic signed [15:0] data_b;
  logic [8:0]         addr_c = '0;
  logic signed [31:0] data_c = '0;
  logic               we_c = 1'b0, done = 1'b0;

  int checks = 0, errors = 0;
  int n_start = 0, n_cmpl = 0;
  logic signed [31:0] rd_q[$];
  logic [3:0]         err_q[$];
  logic               rd_issue = 1'b0, rd_issue_d = 1'b0;
  logic signed [31:0] e_rd;
  logic [3:0]         e_err;

  always #50 clk = ~clk;

  mat_mem_1632_resp dut (
    .clk(clk), .reset_n(reset_n),
    .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_raddr(host_raddr), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .host_go(host_go), .busy(busy), .cmpl(cmpl), .err(err), .start(start),
    .addr_a(addr_a), .data_a(data_a), .addr_b(addr_b), .data_b(data_b),
    .addr_c(addr_c), .data_c(data_c), .we_c(we_c), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares DUT responses against the scoreboard queues.
  always @(posedge clk) rd_issue_d <= rd_issue;

  always @(negedge clk) begin
    if (start) n_start++;
    if (cmpl) begin
      n_cmpl++;
      if (err_q.size() == 0) chk("cmpl_unexpected", 32'(cmpl), 32'(0));
      else begin
        e_err = err_q.pop_front();
        chk("cmpl_err", 32'(err), 32'(e_err));
      end
    end
    if (rd_issue_d) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 32'(host_rvalid), 32'(0));
      else begin
        e_rd = rd_q.pop_front();
        chk("rd_valid", 32'(host_rvalid), 32'(1));
        chk("rd_data", host_rdata, e_rd);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic host_write(input logic sel, input logic [10:0] a, input logic signed [15:0] d);
    host_we = 1'b1; host_sel = sel; host_addr = a; host_wdata = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic pulse_go();
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
  endtask

  task automatic c_write(input logic [8:0] a, input logic signed [31:0] d);
    we_c = 1'b1; addr_c = a; data_c = d;
    tick();
    we_c = 1'b0;
  endtask

  task automatic finish_run(input logic [3:0] exp_err);
    err_q.push_back(exp_err);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  task automatic readback(input logic [8:0] a, input logic signed [31:0] exp);
    host_raddr = a; rd_issue = 1'b1;
    rd_q.push_back(exp);
    tick();
    rd_issue = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    // reset state
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_cmpl", 32'(cmpl), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rvalid", 32'(host_rvalid), 0);
    chk("rst_rdata", host_rdata, 0);
    reset_n = 1'b1;
    tick();

    // full run: A=1, B=2, every C word = 49*1*2 = 98
    for (int i = 0; i < 784; i++) host_write(1'b0, 11'(i), 16'sd1);
    for (int i = 0; i < 1568; i++) host_write(1'b1, 11'(i), 16'sd2);
    chk("load_err", 32'(err), 0);
    pulse_go();
    chk("start_busy", 32'(busy), 1);
    tick();
    for (int i = 0; i < 512; i++) begin
      acc = 0;
      for (int k = 0; k < 49; k++) begin
        addr_a = 10'((i / 32) * 49 + k);
        addr_b = 11'(k * 32 + (i % 32));
        #1;
        acc += data_a * data_b;
      end
      c_write(9'(i), acc);
    end
    finish_run(4'b0000);
    chk("idle_busy", 32'(busy), 0);
    for (int i = 0; i < 512; i++) readback(9'(i), 32'sd98);
    tick();
    chk("run1_starts", n_start, 1);
    chk("run1_cmpls", n_cmpl, 1);

    // we_c while idle: dropped, err[2]; host range error: err[1]
    c_write(9'd3, 32'sd123);
    chk("unexp_err", 32'(err), 32'(4'b0100));
    readback(9'd3, 32'sd98);
    host_write(1'b0, 11'd800, 16'sd5);
    chk("range_err", 32'(err), 32'(4'b0110));
    addr_a = 10'd783; #1; chk("rd_a_last", data_a, 1);
    addr_a = 10'd800; #1; chk("rd_a_oob", data_a, 0);
    addr_b = 11'd1567; #1; chk("rd_b_last", data_b, 2);
    addr_b = 11'd1568; #1; chk("rd_b_oob", data_b, 0);
    chk("idle_rvalid", 32'(host_rvalid), 1);

    // go clears err; done after 511 writes -> err[0]
    pulse_go();
    chk("go_clears_err", 32'(err), 0);
    tick();
    for (int i = 0; i < 511; i++) c_write(9'(i), i);
    finish_run(4'b0001);
    readback(9'd0, 0);
    readback(9'd510, 510);
    readback(9'd511, 98);

    // 512th write together with done; host writes / go ignored in RUN
    pulse_go();
    tick();
    for (int i = 0; i < 511; i++) c_write(9'(i), 1000 + i);
    host_write(1'b0, 11'd0, 16'sd77);
    host_go = 1'b1; tick(); host_go = 1'b0;
    chk("run_hostwe_noerr", 32'(err), 0);
    chk("run_busy", 32'(busy), 1);
    err_q.push_back(4'b0000);
    we_c = 1'b1; addr_c = 9'd511; data_c = 32'sd7777; done = 1'b1;
    tick();
    we_c = 1'b0; done = 1'b0;
    tick();
    readback(9'd0, 1000);
    readback(9'd511, 7777);
    addr_a = 10'd0; #1; chk("a0_unchanged", data_a, 1);

    // duplicate write to addr 5 (512 writes total)
    pulse_go();
    tick();
    for (int i = 0; i < 511; i++) c_write(9'(i), (i == 5) ? 32'sh55 : 32'sd0);
    c_write(9'd5, 32'sh66);
    finish_run(DUP_ERR);
    readback(9'd5, 32'sh66);

    // reset mid-RUN aborts without cmpl, then a clean run
    pulse_go();
    tick();
    for (int i = 0; i < 10; i++) c_write(9'(i), 5);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_cmpl", 32'(cmpl), 0);
    chk("abort_err", 32'(err), 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("abort_no_cmpl", n_cmpl, 4);
    pulse_go();
    tick();
    for (int i = 0; i < 512; i++) c_write(9'(i), -i);
    finish_run(4'b0000);
    readback(9'd100, -100);
    readback(9'd511, -511);
    tick(); tick();

    chk("total_starts", n_start, 6);
    chk("total_cmpls", n_cmpl, 5);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
